// File: rtl/jtframe_ddrarb_pkg.sv
// Shared types and constants for the MiSTer DDR burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtframe_ddrarb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_LD,
        GRANT_ROT,
        RD_WAIT,
        WR_BURST
    } state_t;

    localparam logic OWN_LD  = 1'b0;
    localparam logic OWN_ROT = 1'b1;

    localparam int DEF_AW = 29;
    localparam int DEF_BW = 8;
    localparam int BE_W   = 8;

endpackage

// File: rtl/jtframe_ddrarb_beatcnt.sv
// Burst beat counter shared by the read-return and write-burst paths.
// Latency: last is combinational from the registered count.
// Backpressure: advances only on en; load restarts with a fresh length.
module jtframe_ddrarb_beatcnt #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [BW-1:0] load_len,
    input  logic          first_done,
    input  logic          en,
    output logic          last
);

    logic [BW-1:0] cnt;
    logic [BW-1:0] len;
    logic [BW-1:0] cnt_nxt;

    assign cnt_nxt = cnt + BW'(1);
    // last means the beat currently being counted completes the burst
    assign last    = (cnt_nxt == len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            len <= '0;
        end else if (load) begin
            len <= (load_len == '0) ? BW'(1) : load_len;
            cnt <= first_done ? BW'(1) : '0;
        end else if (en) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/jtframe_mr_ddrarb.sv
// Burst-aware DDR arbiter: ROM loader vs rotation frame buffer; JTFRAME_DDRARB_WDOG_EN adds a read-return watchdog.
// Latency: one cycle of registered arbitration, then owner signals pass straight through to DDR.
// Backpressure: owner sees ddr_busy as waitrequest; non-owner and idle requesters are held busy.
module jtframe_mr_ddrarb
    import jtframe_ddrarb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int BW          = DEF_BW,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic [BW-1:0]   ld_burstcnt,
    input  logic [AW-1:0]   ld_addr,
    input  logic            ld_rd,
    output logic            ld_busy,
    output logic            ld_dout_ready,
    input  logic [BW-1:0]   rot_burstcnt,
    input  logic [AW-1:0]   rot_addr,
    input  logic            rot_rd,
    input  logic            rot_we,
    input  logic [BE_W-1:0] rot_be,
    output logic            rot_busy,
    output logic            rot_dout_ready,
    output logic            ddr_clk,
    input  logic            ddr_busy,
    input  logic            ddr_dout_ready,
    output logic [BW-1:0]   ddr_burstcnt,
    output logic [AW-1:0]   ddr_addr,
    output logic            ddr_rd,
    output logic            ddr_we,
    output logic [BE_W-1:0] ddr_be,
    output logic            wdog_err
);

    state_t state;
    logic   owner;
    logic   accept;
    logic   bc_load;
    logic   beat_en;
    logic   last_beat;

    assign ddr_clk = clk;
    assign accept  = (ddr_rd | ddr_we) & ~ddr_busy;
    assign bc_load = accept & ((state == GRANT_LD) | (state == GRANT_ROT));
    assign beat_en = ((state == RD_WAIT) & ddr_dout_ready) | ((state == WR_BURST) & accept);

    // Returned beats only reach the master that owns the outstanding read
    assign ld_dout_ready  = (state == RD_WAIT) & (owner == OWN_LD)  & ddr_dout_ready;
    assign rot_dout_ready = (state == RD_WAIT) & (owner == OWN_ROT) & ddr_dout_ready;

    jtframe_ddrarb_beatcnt #(.BW(BW)) u_beatcnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (bc_load),
        .load_len   (ddr_burstcnt),
        .first_done (ddr_we),
        .en         (beat_en),
        .last       (last_beat)
    );

    always_comb begin
        ddr_rd       = 1'b0;
        ddr_we       = 1'b0;
        ddr_addr     = '0;
        ddr_burstcnt = '0;
        ddr_be       = '0;
        ld_busy      = 1'b1;
        rot_busy     = 1'b1;
        case (state)
            GRANT_LD: begin
                ddr_rd       = ld_rd;
                ddr_addr     = ld_addr;
                ddr_burstcnt = ld_burstcnt;
                ddr_be       = {BE_W{1'b1}};
                ld_busy      = ddr_busy;
            end
            GRANT_ROT: begin
                ddr_rd       = rot_rd;
                ddr_we       = rot_we & ~rot_rd;
                ddr_addr     = rot_addr;
                ddr_burstcnt = rot_burstcnt;
                ddr_be       = rot_be;
                rot_busy     = ddr_busy;
            end
            WR_BURST: begin
                ddr_we       = rot_we;
                ddr_addr     = rot_addr;
                ddr_burstcnt = rot_burstcnt;
                ddr_be       = rot_be;
                rot_busy     = ddr_busy;
            end
            default: ;
        endcase
    end

`ifdef JTFRAME_DDRARB_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    logic [WW-1:0] wdog_cnt;
    logic          wdog_q;
    assign wdog_err = wdog_q;
`else
    // No watchdog in this build: constant low, parameter kept for interface compatibility
    assign wdog_err = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= OWN_LD;
`ifdef JTFRAME_DDRARB_WDOG_EN
            wdog_cnt <= '0;
            wdog_q   <= 1'b0;
`endif
        end else begin
`ifdef JTFRAME_DDRARB_WDOG_EN
            wdog_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (downloading & ld_rd) begin
                        state <= GRANT_LD;
                        owner <= OWN_LD;
                    end else if (rot_rd | rot_we) begin
                        state <= GRANT_ROT;
                        owner <= OWN_ROT;
                    end else if (ld_rd) begin
                        state <= GRANT_LD;
                        owner <= OWN_LD;
                    end
                end
                GRANT_LD: begin
                    if (accept)
                        state <= RD_WAIT;
                    else if (!ld_rd)
                        state <= IDLE;
                end
                GRANT_ROT: begin
                    if (accept) begin
                        if (ddr_rd)
                            state <= RD_WAIT;
                        else if (rot_burstcnt <= BW'(1))
                            state <= IDLE;
                        else
                            state <= WR_BURST;
                    end else if (!(rot_rd | rot_we)) begin
                        state <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (ddr_dout_ready & last_beat)
                        state <= IDLE;
                end
                WR_BURST: begin
                    if (accept & last_beat)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef JTFRAME_DDRARB_WDOG_EN
            // Silence is measured between returned beats, not from burst start
            if ((state != RD_WAIT) || ddr_dout_ready) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt == WW'(WDOG_CYCLES - 1)) begin
                wdog_cnt <= '0;
                wdog_q   <= 1'b1;
                state    <= IDLE;
            end else begin
                wdog_cnt <= wdog_cnt + WW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_jtframe_mr_ddrarb.sv
// Scoreboard bench for the DDR arbiter: expected DDR commands and read-beat owners are queued at stimulus time.
module tb_jtframe_mr_ddrarb;
    import jtframe_ddrarb_pkg::*;

    localparam int AW = 29;
    localparam int BW = 8;
    localparam int WD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          downloading = 1'b0;
    logic [BW-1:0] ld_burstcnt = '0;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_rd = 1'b0;
    logic          ld_busy, ld_dout_ready;
    logic [BW-1:0] rot_burstcnt = '0;
    logic [AW-1:0] rot_addr = '0;
    logic          rot_rd = 1'b0;
    logic          rot_we = 1'b0;
    logic [7:0]    rot_be = '0;
    logic          rot_busy, rot_dout_ready;
    logic          ddr_clk;
    logic          ddr_busy = 1'b0;
    logic          ddr_dout_ready = 1'b0;
    logic [BW-1:0] ddr_burstcnt;
    logic [AW-1:0] ddr_addr;
    logic          ddr_rd, ddr_we;
    logic [7:0]    ddr_be;
    logic          wdog_err;

    always #5 clk = ~clk;

    jtframe_mr_ddrarb #(.AW(AW), .BW(BW), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ld_burstcnt(ld_burstcnt), .ld_addr(ld_addr), .ld_rd(ld_rd),
        .ld_busy(ld_busy), .ld_dout_ready(ld_dout_ready),
        .rot_burstcnt(rot_burstcnt), .rot_addr(rot_addr), .rot_rd(rot_rd),
        .rot_we(rot_we), .rot_be(rot_be), .rot_busy(rot_busy),
        .rot_dout_ready(rot_dout_ready), .ddr_clk(ddr_clk), .ddr_busy(ddr_busy),
        .ddr_dout_ready(ddr_dout_ready), .ddr_burstcnt(ddr_burstcnt),
        .ddr_addr(ddr_addr), .ddr_rd(ddr_rd), .ddr_we(ddr_we), .ddr_be(ddr_be),
        .wdog_err(wdog_err)
    );

    typedef struct {
        bit            rd;
        bit            own;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        logic [7:0]    be;
    } cmd_t;

    typedef struct {
        bit own;
        int left;
    } rd_t;

    cmd_t exp_q[$];
    rd_t  rd_q[$];

    int n_chk = 0;
    int n_err = 0;
    int rd_pending = 0;
    int resp_budget = -1;
    int busy_mode = 0;
    int wr_left = 0;
    int wr_beats = 0;
    int ld_beats = 0;
    int rot_beats = 0;
    int wdog_pulses = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk_cmd(input bit rd, input bit own, input logic [AW-1:0] a,
                                    input logic [BW-1:0] l, input logic [7:0] be);
        cmd_t c;
        c.rd = rd; c.own = own; c.addr = a; c.len = l; c.be = be;
        return c;
    endfunction

    // DDR model: waitrequest pattern plus read-beat return for accepted reads
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (busy_mode)
                0:       ddr_busy = 1'b0;
                1:       ddr_busy = ~ddr_busy;
                default: ddr_busy = ($urandom_range(0, 3) == 0);
            endcase
            if (rd_pending > 0 && resp_budget != 0 && $urandom_range(0, 3) != 0) begin
                ddr_dout_ready = 1'b1;
                rd_pending--;
                if (resp_budget > 0) resp_budget--;
            end else begin
                ddr_dout_ready = 1'b0;
            end
        end
    end

    // Monitor: compares each accepted command and each forwarded beat with the scoreboard
    always @(negedge clk) begin
        cmd_t e;
        rd_t  r;
        if (rst_n) begin
            if ((ddr_rd | ddr_we) && !ddr_busy) begin
                if (ddr_we && wr_left > 0) begin
                    wr_left--;
                    wr_beats++;
                end else if (exp_q.size() == 0) begin
                    check_val("unexpected_cmd", {ddr_rd, ddr_we}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    check_val("cmd_rd", ddr_rd, e.rd);
                    check_val("cmd_we", ddr_we, !e.rd);
                    check_val("cmd_addr", ddr_addr, e.addr);
                    check_val("cmd_len", ddr_burstcnt, e.len);
                    check_val("cmd_be", ddr_be, e.be);
                    if (ddr_rd) begin
                        check_val("one_outstanding", rd_q.size(), 0);
                        check_val("rd_during_wr", wr_left, 0);
                        r.own = e.own;
                        r.left = (e.len == 0) ? 1 : int'(e.len);
                        rd_q.push_back(r);
                        rd_pending += r.left;
                    end else begin
                        wr_beats++;
                        wr_left = (e.len == 0) ? 0 : int'(e.len) - 1;
                    end
                end
            end
            if (ld_dout_ready || rot_dout_ready) begin
                if (ld_dout_ready) ld_beats++;
                if (rot_dout_ready) rot_beats++;
                check_val("beat_src", ddr_dout_ready, 1);
                if (rd_q.size() == 0) begin
                    check_val("stray_beat", {ld_dout_ready, rot_dout_ready}, 2'b00);
                end else begin
                    r = rd_q[0];
                    check_val("beat_owner", {ld_dout_ready, rot_dout_ready},
                              (r.own == OWN_LD) ? 2'b10 : 2'b01);
                    r.left--;
                    if (r.left == 0) void'(rd_q.pop_front());
                    else rd_q[0] = r;
                end
            end
            if (wdog_err) wdog_pulses++;
        end
    end

    task automatic do_req(input bit is_ld, input bit is_we, input logic [AW-1:0] a,
                          input logic [BW-1:0] len, input logic [7:0] be);
        int n, t, beats;
        beats = is_we ? ((len == 0) ? 1 : int'(len)) : 1;
        @(posedge clk);
        #1;
        if (is_ld) begin
            ld_addr = a; ld_burstcnt = len; ld_rd = 1'b1;
        end else begin
            rot_addr = a; rot_burstcnt = len; rot_be = be; rot_rd = !is_we; rot_we = is_we;
        end
        n = 0;
        t = 0;
        while (n < beats && t < 2000) begin
            @(negedge clk);
            t++;
            if (!(is_ld ? ld_busy : rot_busy)) n++;
            if (n < beats) @(posedge clk);
        end
        if (is_ld) begin
            if (n < beats) check_val("ld_req_timeout", n, beats);
        end else begin
            if (n < beats) check_val("rot_req_timeout", n, beats);
        end
        @(posedge clk);
        #1;
        if (is_ld) ld_rd = 1'b0;
        else begin rot_rd = 1'b0; rot_we = 1'b0; end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0 || wr_left != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, "_done"}, (exp_q.size() == 0 && rd_q.size() == 0 && wr_left == 0), 1);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_ddr_rd"}, ddr_rd, 0);
        check_val({tag, "_ddr_we"}, ddr_we, 0);
        check_val({tag, "_ddr_burstcnt"}, ddr_burstcnt, 0);
        check_val({tag, "_ddr_addr"}, ddr_addr, 0);
        check_val({tag, "_ddr_be"}, ddr_be, 0);
        check_val({tag, "_ld_busy"}, ld_busy, 1);
        check_val({tag, "_rot_busy"}, rot_busy, 1);
        check_val({tag, "_dout_ready"}, {ld_dout_ready, rot_dout_ready}, 2'b00);
        check_val({tag, "_wdog_err"}, wdog_err, 0);
        check_val({tag, "_ddr_clk"}, ddr_clk, clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: time %0t exceeded limit", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        int l0, r0, w0, t;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: loader burst during download
        downloading = 1'b1;
        busy_mode = 2;
        l0 = ld_beats; r0 = rot_beats;
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h100, 8'd4, 8'hff));
        do_req(1, 0, 29'h100, 8'd4, 8'h00);
        wait_done("t1");
        check_val("t1_ld_beats", ld_beats - l0, 4);
        check_val("t1_rot_beats", rot_beats - r0, 0);

        // 2: simultaneous requests outside download, rotation first
        downloading = 1'b0;
        l0 = ld_beats; r0 = rot_beats;
        exp_q.push_back(mk_cmd(1, OWN_ROT, 29'h2000, 8'd4, 8'h0f));
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h300, 8'd2, 8'hff));
        fork
            do_req(1, 0, 29'h300, 8'd2, 8'h00);
            do_req(0, 0, 29'h2000, 8'd4, 8'h0f);
        join
        wait_done("t2");
        check_val("t2_ld_beats", ld_beats - l0, 2);
        check_val("t2_rot_beats", rot_beats - r0, 4);

        // 3: rotation write burst under toggling waitrequest, loader queued behind it
        busy_mode = 1;
        w0 = wr_beats; l0 = ld_beats;
        exp_q.push_back(mk_cmd(0, OWN_ROT, 29'h4000, 8'd8, 8'h3c));
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h500, 8'd1, 8'hff));
        fork
            do_req(0, 1, 29'h4000, 8'd8, 8'h3c);
            begin
                repeat (3) @(posedge clk);
                do_req(1, 0, 29'h500, 8'd1, 8'h00);
            end
        join
        wait_done("t3");
        check_val("t3_wr_beats", wr_beats - w0, 8);
        check_val("t3_ld_beats", ld_beats - l0, 1);

        // 4: download ends while loader read is in flight
        busy_mode = 0;
        downloading = 1'b1;
        l0 = ld_beats; r0 = rot_beats;
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h600, 8'd4, 8'hff));
        exp_q.push_back(mk_cmd(1, OWN_ROT, 29'h7000, 8'd2, 8'hf0));
        do_req(1, 0, 29'h600, 8'd4, 8'h00);
        downloading = 1'b0;
        do_req(0, 0, 29'h7000, 8'd2, 8'hf0);
        wait_done("t4");
        check_val("t4_ld_beats", ld_beats - l0, 4);
        check_val("t4_rot_beats", rot_beats - r0, 2);

        // 5: reset after two of four returned beats
        downloading = 1'b1;
        resp_budget = 2;
        l0 = ld_beats;
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h800, 8'd4, 8'hff));
        do_req(1, 0, 29'h800, 8'd4, 8'h00);
        t = 0;
        while (ld_beats - l0 < 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_val("t5_two_beats", ld_beats - l0, 2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset("t5");
        rd_q.delete();
        exp_q.delete();
        wr_left = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        resp_budget = -1;
        l0 = ld_beats + rot_beats;
        t = 0;
        while (rd_pending > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check_val("t5_stray_ignored", ld_beats + rot_beats - l0, 0);
        downloading = 1'b0;
        r0 = rot_beats;
        exp_q.push_back(mk_cmd(1, OWN_ROT, 29'h1234, 8'd3, 8'h81));
        do_req(0, 0, 29'h1234, 8'd3, 8'h81);
        wait_done("t5_recover");
        check_val("t5_rot_beats", rot_beats - r0, 3);

`ifdef JTFRAME_DDRARB_WDOG_EN
        // 6: no read data ever returns
        downloading = 1'b1;
        resp_budget = 0;
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'h900, 8'd2, 8'hff));
        do_req(1, 0, 29'h900, 8'd2, 8'h00);
        t = 0;
        while (t < 100) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            if (wdog_err) break;
        end
        check_val("wdog_cycles", t, WD);
        @(negedge clk);
        check_val("wdog_pulse_width", wdog_err, 0);
        check_val("wdog_idle_busy", {ld_busy, rot_busy}, 2'b11);
        rd_q.delete();
        rd_pending = 0;
        resp_budget = -1;
        l0 = ld_beats;
        exp_q.push_back(mk_cmd(1, OWN_LD, 29'hA00, 8'd2, 8'hff));
        do_req(1, 0, 29'hA00, 8'd2, 8'h00);
        wait_done("t6_recover");
        check_val("t6_ld_beats", ld_beats - l0, 2);
        check_val("wdog_pulses", wdog_pulses, 1);
`else
        check_val("wdog_quiet", wdog_pulses, 0);
`endif

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
